// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues word reads, buffers in-order responses for decode.
// Optional FE_MISALIGN_CHECK_EN: a misaligned redirect raises a sticky fetch_fault instead of being truncated.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_raw_bits,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = CW + 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  logic [31:0]  pc_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] occupancy;
  logic [DW-1:0] drop_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  fetch_entry_t  fifo_mem [FIFO_DEPTH];
  fetch_entry_t  head;
  logic [31:0]   target_pc;
  logic [31:0]   tag_pc;
  logic          fault;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_drop;
  logic          push;
  logic          pop;

`ifdef FE_MISALIGN_CHECK_EN
  logic fault_q;

  assign target_pc = redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= |redirect_pc[1:0];
  end

  assign fault = fault_q;
`else
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
  assign fault     = 1'b0;
`endif

  assign fetch_fault = fault;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign rsp_drop    = imem_rsp_valid & (drop_q != '0);
  assign rsp_live    = imem_rsp_valid & (drop_q == '0);
  assign push        = rsp_live & ~redirect_valid;

  // A slot freed by this cycle's decoder pop may be reissued at once; this is what sustains 1 instr/cycle.
  assign occupancy      = count_q + inflight_q - CW'(pop);
  assign imem_req_valid = ~rst & ~redirect_valid & ~fault & (occupancy < CW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Live requests are always consecutive words, so the oldest one's PC is recovered from pc and the count.
  assign tag_pc = pc_q - (32'(inflight_q) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else if (redirect_valid) begin
      // Everything still owed by memory after this edge becomes stale and must be discarded.
      pc_q       <= target_pc;
      drop_q     <= drop_q + DW'(inflight_q) + DW'(req_fire) - DW'(imem_rsp_valid);
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_live);
      if (rsp_drop) drop_q <= drop_q - DW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by count_q and the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{pc: tag_pc, data: imem_rsp_data};
  end

  assign head           = fifo_mem[rd_ptr_q];
  assign instr_raw_bits = instr_valid ? head.data : '0;
  assign instr_pc       = instr_valid ? head.pc   : '0;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Scoreboard bench for rv32i_fetch_unit: an in-order memory model feeds the DUT, a monitor checks decode output.
// Build with +define+FE_MISALIGN_CHECK_EN to exercise the fault path instead of the truncation path.
module tb_rv32i_fetch_unit;
  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_raw_bits;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  rv32i_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_raw_bits (instr_raw_bits),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: in-order responses, configurable latency, optional random ready, accept limit.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int cyc = 0;
  int accepts = 0;
  int acc_limit = 0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;
  bit rand_ready = 1'b0;
  int first_acc_cyc = -1;
  int first_valid_cyc = -1;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;

  always @(negedge clk) begin
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst) begin
      imem_req_ready = 1'b0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_fn(mq[0].addr);
        void'(mq.pop_front());
      end
      imem_req_ready = (accepts < acc_limit) && (!rand_ready || ($urandom_range(0, 1) == 1));
      #1;
      if (imem_req_valid && imem_req_ready) begin
        int d;
        d = cyc + int'($urandom_range(lat_min, lat_max));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{addr: imem_req_addr, due: d});
        if (accepts == 0) first_acc_cyc = cyc;
        accepts++;
      end
    end
  end

  // Monitor: every decoder pop is compared against the next expected PC and its memory word.
  always @(negedge clk) begin
    #3;
    if (!rst && instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr: got pc %h with no expected entry at %0t", instr_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e);
        check("instr_raw_bits", instr_raw_bits, mem_fn(e));
      end
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    acc_limit = 0;
    #4;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0040_0000);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_raw", instr_raw_bits, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_fault", fetch_fault, 0);
    @(negedge clk);
    @(negedge clk);
    mq.delete();
    exp_q.delete();
    accepts = 0;
    last_due = 0;
    rand_ready = 1'b0;
    lat_min = 1;
    lat_max = 1;
    first_acc_cyc = -1;
    first_valid_cyc = -1;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // 1: sequential fetch from RESET_PC, latency and throughput
    do_reset();
    acc_limit = 8;
    instr_ready = 1'b1;
    push_seq(32'h0040_0000, 8);
    wait_drain("t1", 100);
    check("t1_first_valid_latency", 32'(first_valid_cyc - first_acc_cyc), 2);
    check("t1_throughput_span", 32'(last_pop_cyc - first_pop_cyc), 7);

    // 2: decoder stall holds the head and caps outstanding requests
    do_reset();
    acc_limit = 8;
    instr_ready = 1'b0;
    push_seq(32'h0040_0000, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      if (i >= 2) begin
        check("t2_stall_valid", instr_valid, 1);
        check("t2_stall_pc", instr_pc, 32'h0040_0000);
        check("t2_stall_raw", instr_raw_bits, mem_fn(32'h0040_0000));
      end
    end
    check("t2_accepts_during_stall", accepts, 2);
    @(negedge clk);
    instr_ready = 1'b1;
    wait_drain("t2", 100);

    // 3: redirect with two requests outstanding drops both responses
    do_reset();
    lat_min = 3;
    lat_max = 3;
    acc_limit = 5;
    instr_ready = 1'b1;
    begin
      int n = 0;
      while (accepts < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t3_two_inflight", accepts, 2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1000;
    #4;
    check("t3_no_req_in_redirect", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    push_seq(32'h0000_1000, 3);
    #4;
    check("t3_valid_after_redirect", instr_valid, 0);
    wait_drain("t3", 100);

    // 3b: redirect while the buffer is full; the pop in the redirect cycle still completes
    do_reset();
    acc_limit = 6;
    instr_ready = 1'b0;
    exp_q.push_back(32'h0040_0000);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    push_seq(32'h0000_3000, 4);
    #4;
    check("t3b_valid_after_redirect", instr_valid, 0);
    wait_drain("t3b", 100);

    // 4: PC wraps from 0xFFFF_FFFC to 0
    do_reset();
    acc_limit = 4;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    push_seq(32'hFFFF_FFF8, 4);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_drain("t4", 100);

    // 5: random memory ready, latency 1..3, random decoder ready
    do_reset();
    rand_ready = 1'b1;
    lat_min = 1;
    lat_max = 3;
    acc_limit = 20;
    push_seq(32'h0040_0000, 20);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
        @(negedge clk);
        instr_ready = ($urandom_range(0, 1) == 1);
        n++;
      end
    end
    instr_ready = 1'b1;
    wait_drain("t5", 20);

`ifdef FE_MISALIGN_CHECK_EN
    // 6: misaligned redirect faults and stalls fetch until an aligned redirect
    do_reset();
    acc_limit = 3;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1002;
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t6_fault_set", fetch_fault, 1);
    repeat (5) @(negedge clk);
    #4;
    check("t6_no_req_valid", imem_req_valid, 0);
    check("t6_no_accepts", accepts, 0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    push_seq(32'h0000_2000, 3);
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t6_fault_cleared", fetch_fault, 0);
    wait_drain("t6", 100);
`else
    // 6: misaligned redirect target is truncated to a word boundary
    do_reset();
    acc_limit = 2;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5006;
    push_seq(32'h0000_5004, 2);
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t6_fault_tied_low", fetch_fault, 0);
    wait_drain("t6", 100);
`endif

    // 7: reset while the buffer is full clears outputs immediately
    do_reset();
    acc_limit = 8;
    instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    #4;
    check("t7_full_before_reset", instr_valid, 1);
    do_reset();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
